ysyx_imem_resp: RTL and testbench
=================================

# ysyx_imem_resp

Instruction-memory responder on the fetch bus: the responder end of the IFU read channel (`araddr`/`arvalid` in, `rdata`/`rvalid` out). It captures one read request, waits a configurable (optionally pseudo-random) latency, and returns one word with a single-cycle `rvalid` pulse. It sits behind the IFU in simulation and FPGA builds and stands in for the external instruction SRAM. A side write port preloads the program image.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data/word width.
- `DEPTH_W`, 12, log2 of memory depth in words (4096 words).
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0; must be aligned to 4·2^DEPTH_W.
- `LAT_MIN`, 1, fixed wait cycles; legal range 1..15.
- `LFSR_EN`, 0, when 1, adds `lfsr[1:0]` (0..3) extra wait cycles per request.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-low (rst=0 resets on the next rising edge).
- `araddr`  in  ADDR_W  request byte address, sampled only when accepted.
- `arvalid`  in  1  request valid.
- `rdata`  out  DATA_W  read word; meaningful only while `rvalid`=1.
- `rvalid`  out  1  single-cycle response strobe.
- `rerr`  out  1  access fault, qualified by `rvalid`.
- `wen`  in  1  preload write enable.
- `waddr`  in  ADDR_W  preload byte address.
- `wdata`  in  DATA_W  preload word.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `arvalid`=1 accepts the request. On acceptance, latch `araddr`, set `cnt <= D-1` with `D = LAT_MIN + (LFSR_EN ? lfsr[1:0] : 0)`, step the LFSR, and go to BUSY. Otherwise stay in IDLE.
- BUSY: if `cnt`==0, register the memory word (or fault result) into `rdata`/`rerr`, set `rvalid`=1, and go to RESP. Otherwise decrement `cnt`.
- RESP: `rvalid`=1 for exactly this cycle. Clear `rvalid` and `rerr`, then go to IDLE. A request arriving this cycle is ignored and must be held into IDLE.
- Address decode on the latched address:
  - In range means `addr[ADDR_W-1:DEPTH_W+2] == BASE_ADDR[ADDR_W-1:DEPTH_W+2]` and `addr[1:0]`==0.
  - Index is `addr[DEPTH_W+1:2]`.
  - Out-of-range or misaligned: `rdata`=0, `rerr`=1.
- Request-hold semantics:
  - `arvalid` held high after a response starts a new request in the following IDLE cycle; the requester deasserts it to avoid refetch.
  - `arvalid` dropping or `araddr` changing during BUSY has no effect; the latched request completes.
- Preload write: when `wen`=1 and `waddr` is in range and aligned, write `mem[idx] <= wdata` in any state. Other writes are silently dropped.
- Read and write to the same word in the same cycle: read returns the old data.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5. Steps only on request acceptance. Never all-zero.
- Memory contents are not reset. Preload precedes first fetch.

## Timing
- Reset values: `rvalid`=0, `rdata`=0, `rerr`=0, state=IDLE, `cnt`=0, `lfsr`=8'hA5.
- Latency: request accepted at edge T gives `rvalid`=1 in cycle T+D+1. With `LAT_MIN`=1 and `LFSR_EN`=0, `rvalid` arrives 2 cycles after acceptance.
- Throughput: one response per D+2 cycles under continuously held `arvalid`.
- `rdata`/`rerr` are registered, with no combinational path from `araddr`/`arvalid`.
- `rst`=0 at any point, including BUSY or RESP: the pending request is dropped and no `rvalid` is issued. On release, the block restarts in IDLE with the LFSR reseeded.
- `cnt` is 5 bits wide to cover D ≤ 18 without wrap.

## Test plan
- Preload `mem[0]=32'h0000_0413` via `wen` at `waddr`=32'h8000_0000. Pulse `arvalid` one cycle with that address, LAT_MIN=1 -> `rvalid` exactly one cycle, 2 cycles after acceptance, `rdata`=32'h0000_0413, `rerr`=0.
- `arvalid` held high with address 32'h8000_0004 -> `rvalid` pulses every 3 cycles, each with `mem[1]`.
- `araddr`=32'h7FFF_FFFC, then 32'h8000_0002 -> `rvalid` with `rdata`=0 and `rerr`=1 for each.
- LAT_MIN=2, LFSR_EN=1, 64 back-to-back requests -> every latency falls in 3..6 cycles and matches a reference LFSR seeded 8'hA5.
- `rst`=0 asserted in the second BUSY cycle -> no `rvalid` afterwards. A fresh request after release completes normally.
- Write 32'hDEAD_BEEF to the word being read at the BUSY cnt==0 edge -> response carries the old word. The next read returns 32'hDEAD_BEEF.

Source files
------------

// File: rtl/ysyx_imem_resp.sv
// Instruction-memory responder for the IFU read channel: one request in flight,
// fixed or LFSR-jittered latency, single-cycle rvalid, plus a preload write port.
module ysyx_imem_resp #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH_W   = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LAT_MIN   = 1,
  parameter int                LFSR_EN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rerr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [4:0]          r_cnt;
  logic [7:0]          r_lfsr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_rerr;
  logic [DATA_W-1:0]   r_mem [0:(1<<DEPTH_W)-1];

  logic                w_accept;
  logic                w_fire;
  logic [4:0]          w_delay;
  logic [7:0]          w_lfsr_next;
  logic                w_rd_hit;
  logic [DEPTH_W-1:0]  w_rd_idx;
  logic                w_wr_hit;
  logic [DEPTH_W-1:0]  w_wr_idx;

  assign w_accept    = (r_state == S_IDLE) && arvalid;
  assign w_fire      = (r_state == S_BUSY) && (r_cnt == 5'd0);
  assign w_delay     = 5'(LAT_MIN) + ((LFSR_EN != 0) ? {3'b000, r_lfsr[1:0]} : 5'd0);
  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  assign w_rd_hit = (r_addr[ADDR_W-1:DEPTH_W+2] == BASE_ADDR[ADDR_W-1:DEPTH_W+2]) &&
                    (r_addr[1:0] == 2'b00);
  assign w_rd_idx = r_addr[DEPTH_W+1:2];
  assign w_wr_hit = (waddr[ADDR_W-1:DEPTH_W+2] == BASE_ADDR[ADDR_W-1:DEPTH_W+2]) &&
                    (waddr[1:0] == 2'b00);
  assign w_wr_idx = waddr[DEPTH_W+1:2];

  // Memory contents are deliberately not reset; the image is preloaded.
  always_ff @(posedge clk) begin
    if (wen && w_wr_hit) begin
      r_mem[w_wr_idx] <= wdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (arvalid) w_state_next = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd0) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= 5'd0;
      r_lfsr   <= 8'hA5;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr <= araddr;
        r_cnt  <= w_delay - 5'd1;
        r_lfsr <= w_lfsr_next;
      end else if ((r_state == S_BUSY) && (r_cnt != 5'd0)) begin
        r_cnt <= r_cnt - 5'd1;
      end
      // A same-edge preload write is not visible here: the read sees the old word.
      if (w_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_hit ? r_mem[w_rd_idx] : '0;
        r_rerr   <= ~w_rd_hit;
      end else if (r_state == S_RESP) begin
        r_rvalid <= 1'b0;
        r_rerr   <= 1'b0;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign rerr   = r_rerr;

endmodule

// File: tb/tb_ysyx_imem_resp.sv
// Scoreboard bench: expected {data, err, cycle} entries are queued at stimulus
// time and checked by per-instance monitors when rvalid appears.
module tb_ysyx_imem_resp;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] araddr_a, araddr_b;
  logic        arvalid_a, arvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        rerr_a, rerr_b;
  logic        wen;
  logic [31:0] waddr, wdata;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [7:0] m_lfsr = 8'hA5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_imem_resp #(.LAT_MIN(1), .LFSR_EN(0)) u_a (
    .clk(clk), .rst(rst_a), .araddr(araddr_a), .arvalid(arvalid_a),
    .rdata(rdata_a), .rvalid(rvalid_a), .rerr(rerr_a),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  ysyx_imem_resp #(.LAT_MIN(2), .LFSR_EN(1)) u_b (
    .clk(clk), .rst(rst_b), .araddr(araddr_b), .arvalid(arvalid_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .rerr(rerr_b),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always @(negedge clk) begin
    if (rvalid_a === 1'b1) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_rvalid cyc=%0d rdata=%h rerr=%b expected no response", cyc, rdata_a, rerr_a);
      end else begin
        e_a = q_a.pop_front();
        if (rdata_a !== e_a.data || rerr_a !== e_a.err || cyc !== e_a.cyc) begin
          bad++;
          $display("FAIL a_resp got rdata=%h rerr=%b cyc=%0d expected rdata=%h rerr=%b cyc=%0d",
                   rdata_a, rerr_a, cyc, e_a.data, e_a.err, e_a.cyc);
        end else begin
          $display("a resp rdata=%h rerr=%b cyc=%0d ok", rdata_a, rerr_a, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid_b === 1'b1) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_rvalid cyc=%0d rdata=%h rerr=%b expected no response", cyc, rdata_b, rerr_b);
      end else begin
        e_b = q_b.pop_front();
        if (rdata_b !== e_b.data || rerr_b !== e_b.err || cyc !== e_b.cyc) begin
          bad++;
          $display("FAIL b_resp got rdata=%h rerr=%b cyc=%0d expected rdata=%h rerr=%b cyc=%0d",
                   rdata_b, rerr_b, cyc, e_b.data, e_b.err, e_b.cyc);
        end else begin
          $display("b resp rdata=%h rerr=%b cyc=%0d ok", rdata_b, rerr_b, cyc);
        end
      end
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic er, input int c);
    exp_t e;
    e.data = d;
    e.err  = er;
    e.cyc  = c;
    return e;
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending_a=%0d pending_b=%0d required 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  // One-cycle request on instance A; address is scrambled afterwards.
  task automatic pulse_a(input logic [31:0] a, input logic [31:0] d, input logic er);
    @(negedge clk);
    arvalid_a = 1'b1; araddr_a = a;
    q_a.push_back(mk(d, er, cyc + 2));
    @(negedge clk);
    arvalid_a = 1'b0; araddr_a = 32'h1234_5678;
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    total += 3;
    if (rvalid_a !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b required 0", rvalid_a); end
    if (rdata_a !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h required 0", rdata_a); end
    if (rerr_a !== 1'b0) begin bad++; $display("FAIL reset_rerr got %b required 0", rerr_a); end
    rst_a = 1'b1; rst_b = 1'b1;
    m_lfsr = 8'hA5;
    repeat (2) @(negedge clk);
    total += 3;
    if (rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_b_rvalid got %b required 0", rvalid_b); end
    if (rdata_b !== 32'h0) begin bad++; $display("FAIL reset_b_rdata got %h required 0", rdata_b); end
    if (rerr_b !== 1'b0) begin bad++; $display("FAIL reset_b_rerr got %b required 0", rerr_b); end
    $display("reset checks done");
  endtask

  task automatic test_preload;
    write_word(32'h8000_0000, 32'h0000_0413);
    write_word(32'h8000_0004, 32'h1234_ABCD);
    write_word(32'h8000_0008, 32'hCAFE_F00D);
    write_word(32'h8000_000C, 32'h0BAD_C0DE);
    write_word(32'h8000_4000, 32'hFFFF_FFFF);  // out of range, dropped
    write_word(32'h8000_0005, 32'hEEEE_EEEE);  // misaligned, dropped
  endtask

  task automatic test_basic;
    pulse_a(32'h8000_0000, 32'h0000_0413, 1'b0);
    drain(20);
    pulse_a(32'h8000_0004, 32'h1234_ABCD, 1'b0);
    drain(20);
  endtask

  task automatic test_hold;
    int c;
    @(negedge clk);
    arvalid_a = 1'b1; araddr_a = 32'h8000_0004;
    c = cyc;
    for (int k = 0; k < 3; k++) q_a.push_back(mk(32'h1234_ABCD, 1'b0, c + 2 + 3 * k));
    while (cyc < c + 8) @(negedge clk);
    arvalid_a = 1'b0;
    drain(20);
  endtask

  task automatic test_faults;
    pulse_a(32'h7FFF_FFFC, 32'h0, 1'b1);
    drain(20);
    pulse_a(32'h8000_0002, 32'h0, 1'b1);
    drain(20);
    pulse_a(32'h8000_4000, 32'h0, 1'b1);
    drain(20);
  endtask

  task automatic test_lfsr_back_to_back;
    int a, d, last;
    @(negedge clk);
    arvalid_b = 1'b1; araddr_b = 32'h8000_000C;
    a = cyc;
    last = a;
    for (int k = 0; k < 64; k++) begin
      d = 2 + int'(m_lfsr[1:0]);
      m_lfsr = lfsr_step(m_lfsr);
      last = a + d + 1;
      q_b.push_back(mk(32'h0BAD_C0DE, 1'b0, last));
      a = a + d + 2;
    end
    while (cyc < last) @(negedge clk);
    arvalid_b = 1'b0;
    drain(100);
  endtask

  task automatic test_reset_in_busy;
    int c, d, seen;
    @(negedge clk);
    arvalid_b = 1'b1; araddr_b = 32'h8000_0008;
    c = cyc;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    arvalid_b = 1'b0;
    while (cyc < c + 2) @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    m_lfsr = 8'hA5;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid_b === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_busy_drop rvalid_count=%0d required 0", seen);
    end
    @(negedge clk);
    arvalid_b = 1'b1; araddr_b = 32'h8000_0008;
    d = 2 + int'(m_lfsr[1:0]);
    m_lfsr = lfsr_step(m_lfsr);
    q_b.push_back(mk(32'hCAFE_F00D, 1'b0, cyc + d + 1));
    @(negedge clk);
    arvalid_b = 1'b0;
    drain(30);
  endtask

  task automatic test_collision;
    int c;
    @(negedge clk);
    arvalid_a = 1'b1; araddr_a = 32'h8000_0008;
    c = cyc;
    q_a.push_back(mk(32'hCAFE_F00D, 1'b0, c + 2));
    @(negedge clk);
    arvalid_a = 1'b0;
    wen = 1'b1; waddr = 32'h8000_0008; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wen = 1'b0;
    drain(20);
    pulse_a(32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
    drain(20);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    arvalid_a = 1'b0; arvalid_b = 1'b0;
    araddr_a = 32'h0; araddr_b = 32'h0;
    wen = 1'b0; waddr = 32'h0; wdata = 32'h0;
    test_reset();
    test_preload();
    test_basic();
    test_hold();
    test_faults();
    test_lfsr_back_to_back();
    test_reset_in_busy();
    test_collision();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
